// File: rtl/fixed_point_accumulator.sv
// Sign-magnitude fixed-point packet accumulator with saturate/wrap overflow,
// sticky overflow flag, term-count limit and valid/ready result handshake.
module fixed_point_accumulator #(
    parameter int unsigned SIGN      = 1,
    parameter int unsigned Q_M       = 16,
    parameter int unsigned Q_N       = 15,
    parameter int unsigned SATURATE  = 1,
    parameter int unsigned MAX_TERMS = 256,
    parameter int unsigned CNT_W     = 9
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      clear_in,
    input  logic [SIGN+Q_M+Q_N-1:0]   data_in,
    input  logic                      data_valid_in,
    input  logic                      data_last_in,
    output logic                      data_ready_out,
    output logic [SIGN+Q_M+Q_N-1:0]   result_out,
    output logic                      result_valid_out,
    input  logic                      result_ready_in,
    output logic                      overflow_out,
    output logic                      forced_out,
    output logic [CNT_W-1:0]          term_count_out
);

    localparam int unsigned W = SIGN + Q_M + Q_N;
    localparam int unsigned M = W - 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               acc_sign_q, acc_sign_d;
    logic [M-1:0]       acc_mag_q, acc_mag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic [W-1:0]       res_q, res_d;
    logic               res_valid_q, res_valid_d;
    logic               res_ovf_q, res_ovf_d;
    logic               res_forced_q, res_forced_d;
    logic [CNT_W-1:0]   res_cnt_q, res_cnt_d;

    logic               d_sign;
    logic [M-1:0]       d_mag;
    logic [M:0]         sum;
    logic [M-1:0]       diff;
    logic               acc_ge;
    logic               add_sign;
    logic [M-1:0]       add_mag;
    logic               add_ovf;
    logic               beat;
    logic               done_now;
    logic               forced_now;

    assign data_ready_out   = (state_q != DONE);
    assign beat             = data_valid_in && data_ready_out;
    assign result_out       = res_q;
    assign result_valid_out = res_valid_q;
    assign overflow_out     = res_ovf_q;
    assign forced_out       = res_forced_q;
    assign term_count_out   = res_cnt_q;

    // Sign-magnitude add of the incoming term onto the accumulator; -0 never survives.
    always_comb begin
        d_mag    = data_in[M-1:0];
        d_sign   = data_in[W-1] && (d_mag != '0);
        sum      = {1'b0, acc_mag_q} + {1'b0, d_mag};
        acc_ge   = (acc_mag_q >= d_mag);
        diff     = acc_ge ? (acc_mag_q - d_mag) : (d_mag - acc_mag_q);
        add_sign = acc_sign_q;
        add_mag  = sum[M-1:0];
        add_ovf  = 1'b0;
        if (acc_sign_q == d_sign) begin
            add_ovf = sum[M];
            if (sum[M] && (SATURATE != 0)) begin
                add_mag = {M{1'b1}};
            end
        end else begin
            add_mag  = diff;
            add_sign = acc_ge ? acc_sign_q : d_sign;
        end
        if (add_mag == '0) begin
            add_sign = 1'b0;
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        acc_sign_d   = acc_sign_q;
        acc_mag_d    = acc_mag_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        res_d        = res_q;
        res_valid_d  = res_valid_q;
        res_ovf_d    = res_ovf_q;
        res_forced_d = res_forced_q;
        res_cnt_d    = res_cnt_q;
        done_now     = 1'b0;
        forced_now   = 1'b0;

        case (state_q)
            IDLE: begin
                if (beat) begin
                    acc_sign_d = d_sign;
                    acc_mag_d  = d_mag;
                    cnt_d      = CNT_W'(1);
                    ovf_d      = 1'b0;
                    if (data_last_in) begin
                        done_now = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (beat) begin
                    acc_sign_d = add_sign;
                    acc_mag_d  = add_mag;
                    cnt_d      = cnt_q + CNT_W'(1);
                    ovf_d      = ovf_q | add_ovf;
                    if (data_last_in) begin
                        done_now = 1'b1;
                    end else if (cnt_d == CNT_W'(MAX_TERMS)) begin
                        done_now   = 1'b1;
                        forced_now = 1'b1;
                    end
                end
            end
            DONE: begin
                if (result_ready_in) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_now) begin
            state_d      = DONE;
            res_valid_d  = 1'b1;
            res_d        = {acc_sign_d, acc_mag_d};
            res_ovf_d    = ovf_d;
            res_forced_d = forced_now;
            res_cnt_d    = cnt_d;
        end

        // Abort wins over any accept or handshake in the same cycle.
        if (clear_in) begin
            state_d      = IDLE;
            acc_sign_d   = 1'b0;
            acc_mag_d    = '0;
            cnt_d        = '0;
            ovf_d        = 1'b0;
            res_valid_d  = 1'b0;
            res_ovf_d    = 1'b0;
            res_forced_d = 1'b0;
            res_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            acc_sign_q   <= 1'b0;
            acc_mag_q    <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            res_q        <= '0;
            res_valid_q  <= 1'b0;
            res_ovf_q    <= 1'b0;
            res_forced_q <= 1'b0;
            res_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            acc_sign_q   <= acc_sign_d;
            acc_mag_q    <= acc_mag_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            res_q        <= res_d;
            res_valid_q  <= res_valid_d;
            res_ovf_q    <= res_ovf_d;
            res_forced_q <= res_forced_d;
            res_cnt_q    <= res_cnt_d;
        end
    end

endmodule

// File: tb/tb_fixed_point_accumulator.sv
// Bench for fixed_point_accumulator: saturating, wrapping and MAX_TERMS=4 instances.
module tb_fixed_point_accumulator;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [1:0]   dut;
        logic [W-1:0] res;
        logic         ovf;
        logic         forced;
        logic [8:0]   cnt;
    } exp_t;

    typedef struct packed {
        logic [1:0]          dut;
        logic [2:0]          n;
        logic [3:0][W-1:0]   t;
        logic [W-1:0]        res;
        logic                ovf;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din [3];
    logic         dv [3];
    logic         dl [3];
    logic         clr [3];
    logic         rrdy [3];
    logic         drdy [3];
    logic [W-1:0] res [3];
    logic         rvld [3];
    logic         ovf [3];
    logic         frc [3];
    logic [8:0]   cnt0, cnt1;
    logic [2:0]   cnt2;

    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    fixed_point_accumulator #(.SATURATE(1), .MAX_TERMS(256), .CNT_W(9)) u_sat (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clr[0]), .data_in(din[0]),
        .data_valid_in(dv[0]), .data_last_in(dl[0]), .data_ready_out(drdy[0]),
        .result_out(res[0]), .result_valid_out(rvld[0]), .result_ready_in(rrdy[0]),
        .overflow_out(ovf[0]), .forced_out(frc[0]), .term_count_out(cnt0));

    fixed_point_accumulator #(.SATURATE(0), .MAX_TERMS(256), .CNT_W(9)) u_wrap (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clr[1]), .data_in(din[1]),
        .data_valid_in(dv[1]), .data_last_in(dl[1]), .data_ready_out(drdy[1]),
        .result_out(res[1]), .result_valid_out(rvld[1]), .result_ready_in(rrdy[1]),
        .overflow_out(ovf[1]), .forced_out(frc[1]), .term_count_out(cnt1));

    fixed_point_accumulator #(.SATURATE(1), .MAX_TERMS(4), .CNT_W(3)) u_lim (
        .clk_in(clk), .rst_n_in(rst_n), .clear_in(clr[2]), .data_in(din[2]),
        .data_valid_in(dv[2]), .data_last_in(dl[2]), .data_ready_out(drdy[2]),
        .result_out(res[2]), .result_valid_out(rvld[2]), .result_ready_in(rrdy[2]),
        .overflow_out(ovf[2]), .forced_out(frc[2]), .term_count_out(cnt2));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] get_cnt(input int k);
        case (k)
            0:       return cnt0;
            1:       return cnt1;
            default: return {6'd0, cnt2};
        endcase
    endfunction

    // Reference sum through signed integers, independent of magnitude tricks.
    function automatic logic [W-1:0] model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                               input bit sat, output bit ov);
        longint va, vb, s, m;
        va = {33'd0, a[30:0]};
        vb = {33'd0, b[30:0]};
        if (a[31]) va = -va;
        if (b[31]) vb = -vb;
        s  = va + vb;
        m  = (s < 0) ? -s : s;
        ov = 1'b0;
        if (m > 64'h7FFF_FFFF) begin
            ov = 1'b1;
            m  = sat ? 64'h7FFF_FFFF : (m - 64'h8000_0000);
        end
        return {(s < 0) && (m != 0), m[30:0]};
    endfunction

    // Scoreboard: compare each handshaked result against the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n) begin
            for (int k = 0; k < 3; k++) begin
                if (rvld[k] && rrdy[k] && !clr[k]) begin
                    if (exp_q.size() == 0 || exp_q[0].dut != 2'(k)) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_result dut%0d: got %h expected none", k, res[k]);
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("result dut%0d", k), 64'(res[k]), 64'(e.res));
                        chk($sformatf("overflow dut%0d", k), 64'(ovf[k]), 64'(e.ovf));
                        chk($sformatf("forced dut%0d", k), 64'(frc[k]), 64'(e.forced));
                        chk($sformatf("count dut%0d", k), 64'(get_cnt(k)), 64'(e.cnt));
                        chk($sformatf("ready_in_done dut%0d", k), 64'(drdy[k]), 64'd0);
                    end
                end
            end
        end
    end

    task automatic beat(input int k, input logic [W-1:0] d, input logic last);
        int   g;
        logic a;
        din[k] = d;
        dv[k]  = 1'b1;
        dl[k]  = last;
        g      = 0;
        do begin
            @(negedge clk);
            a = drdy[k];
            @(posedge clk);
            #1;
            g++;
        end while (!a && g < 100);
        if (!a) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout dut%0d: got no accept expected accept", k);
        end
        dv[k] = 1'b0;
        dl[k] = 1'b0;
    endtask

    task automatic push(input int k, input logic [W-1:0] r, input logic o, input logic f,
                        input logic [8:0] c);
        exp_t e;
        e.dut    = 2'(k);
        e.res    = r;
        e.ovf    = o;
        e.forced = f;
        e.cnt    = c;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 200) begin
            @(posedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        chk("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    endtask

    vec_t vecs [11];

    initial begin
        logic [W-1:0] tt [5];
        logic [W-1:0] acc;
        bit           o, oacc;
        int           n;

        for (int k = 0; k < 3; k++) begin
            din[k] = '0; dv[k] = 1'b0; dl[k] = 1'b0; clr[k] = 1'b0; rrdy[k] = 1'b1;
        end

        vecs[0]  = '{dut:2'd0, n:3'd3, t:{32'h0, 32'h8001_0000, 32'h8000_2000, 32'h0000_C000}, res:32'h8000_6000, ovf:1'b0};
        vecs[1]  = '{dut:2'd0, n:3'd2, t:{32'h0, 32'h0, 32'h8000_8000, 32'h0000_8000}, res:32'h0000_0000, ovf:1'b0};
        vecs[2]  = '{dut:2'd0, n:3'd1, t:{32'h0, 32'h0, 32'h0, 32'h8000_0000}, res:32'h0000_0000, ovf:1'b0};
        vecs[3]  = '{dut:2'd0, n:3'd2, t:{32'h0, 32'h0, 32'h0000_0001, 32'h7FFF_FFFF}, res:32'h7FFF_FFFF, ovf:1'b1};
        vecs[4]  = '{dut:2'd0, n:3'd1, t:{32'h0, 32'h0, 32'h0, 32'h0000_0001}, res:32'h0000_0001, ovf:1'b0};
        vecs[5]  = '{dut:2'd0, n:3'd2, t:{32'h0, 32'h0, 32'h8000_0002, 32'hFFFF_FFFF}, res:32'hFFFF_FFFF, ovf:1'b1};
        vecs[6]  = '{dut:2'd0, n:3'd3, t:{32'h0, 32'h8000_0010, 32'h0000_0001, 32'h7FFF_FFFF}, res:32'h7FFF_FFEF, ovf:1'b1};
        vecs[7]  = '{dut:2'd0, n:3'd4, t:{32'h0000_0001, 32'h8000_0004, 32'h8000_0003, 32'h0000_0005}, res:32'h8000_0001, ovf:1'b0};
        vecs[8]  = '{dut:2'd1, n:3'd2, t:{32'h0, 32'h0, 32'h0000_0001, 32'h7FFF_FFFF}, res:32'h0000_0000, ovf:1'b1};
        vecs[9]  = '{dut:2'd1, n:3'd1, t:{32'h0, 32'h0, 32'h0, 32'h0000_0001}, res:32'h0000_0001, ovf:1'b0};
        vecs[10] = '{dut:2'd1, n:3'd2, t:{32'h0, 32'h0, 32'h8000_0002, 32'hFFFF_FFFF}, res:32'h8000_0001, ovf:1'b1};

        // Reset held with random stimulus
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 3; k++) begin
                din[k] = $urandom; dv[k] = 1'($urandom); dl[k] = 1'($urandom);
                rrdy[k] = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            dv[k] = 1'b0; dl[k] = 1'b0; rrdy[k] = 1'b1;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset result dut%0d", k), 64'(res[k]), 64'd0);
            chk($sformatf("reset valid dut%0d", k), 64'(rvld[k]), 64'd0);
            chk($sformatf("reset ready dut%0d", k), 64'(drdy[k]), 64'd1);
            chk($sformatf("reset ovf_forced dut%0d", k), 64'({ovf[k], frc[k]}), 64'd0);
            chk($sformatf("reset count dut%0d", k), 64'(get_cnt(k)), 64'd0);
        end
        @(posedge clk);
        #1;

        // Table-driven packets
        for (int v = 0; v < 11; v++) begin
            push(int'(vecs[v].dut), vecs[v].res, vecs[v].ovf, 1'b0, 9'(vecs[v].n));
            for (int i = 0; i < int'(vecs[v].n); i++) begin
                beat(int'(vecs[v].dut), vecs[v].t[i], 1'(i == int'(vecs[v].n) - 1));
            end
            drain();
        end

        // Latency: valid appears right after the edge that accepts the last term
        push(0, 32'h8000_6000, 1'b0, 1'b0, 9'd3);
        beat(0, 32'h0000_C000, 1'b0);
        beat(0, 32'h8000_2000, 1'b0);
        chk("valid_before_last", 64'(rvld[0]), 64'd0);
        beat(0, 32'h8001_0000, 1'b1);
        chk("valid_after_last", 64'(rvld[0]), 64'd1);
        drain();

        // Backpressure: result held, no beat accepted
        rrdy[0] = 1'b0;
        push(0, 32'h0000_3000, 1'b0, 1'b0, 9'd2);
        beat(0, 32'h0000_1000, 1'b0);
        beat(0, 32'h0000_2000, 1'b1);
        din[0] = 32'h1234_5678; dv[0] = 1'b1; dl[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_ready_low", 64'(drdy[0]), 64'd0);
            chk("bp_valid_high", 64'(rvld[0]), 64'd1);
            chk("bp_result_stable", 64'(res[0]), 64'h3000);
        end
        @(posedge clk);
        #1;
        dv[0] = 1'b0; dl[0] = 1'b0; rrdy[0] = 1'b1;
        drain();
        push(0, 32'h0000_0007, 1'b0, 1'b0, 9'd1);
        beat(0, 32'h0000_0007, 1'b1);
        drain();

        // Clear mid-packet, with a colliding beat that must be dropped
        beat(0, 32'h0001_0000, 1'b0);
        beat(0, 32'h0002_0000, 1'b0);
        clr[0] = 1'b1; din[0] = 32'h0001_0000; dv[0] = 1'b1; dl[0] = 1'b0;
        @(posedge clk);
        #1;
        clr[0] = 1'b0; dv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("clear_no_result", 64'(rvld[0]), 64'd0);
        push(0, 32'h0000_4000, 1'b0, 1'b0, 9'd1);
        beat(0, 32'h0000_4000, 1'b1);
        drain();

        // Clear beats a result handshake in the same cycle
        rrdy[0] = 1'b0;
        beat(0, 32'h0000_0009, 1'b1);
        chk("done_before_clear", 64'(rvld[0]), 64'd1);
        clr[0] = 1'b1; rrdy[0] = 1'b1;
        @(posedge clk);
        #1;
        clr[0] = 1'b0;
        chk("clear_drops_valid", 64'(rvld[0]), 64'd0);
        chk("clear_ready", 64'(drdy[0]), 64'd1);

        // Term limit on the MAX_TERMS=4 instance
        push(2, 32'h0002_0000, 1'b0, 1'b1, 9'd4);
        for (int i = 0; i < 6; i++) beat(2, 32'h0000_8000, 1'b0);
        drain();
        clr[2] = 1'b1;
        @(posedge clk);
        #1;
        clr[2] = 1'b0;
        push(2, 32'h0000_4000, 1'b0, 1'b0, 9'd1);
        beat(2, 32'h0000_4000, 1'b1);
        drain();

        // Random packets against the integer model
        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(1, 5));
            acc  = '0;
            oacc = 1'b0;
            for (int i = 0; i < n; i++) begin
                tt[i] = $urandom;
                if ($urandom_range(0, 2) != 0) tt[i][30:18] = '0;
                acc = model_add(acc, tt[i], 1'b1, o);
                oacc = oacc | o;
            end
            push(0, acc, oacc, 1'b0, 9'(n));
            for (int i = 0; i < n; i++) beat(0, tt[i], 1'(i == n - 1));
            drain();
        end

        // Asynchronous reset mid-packet
        beat(0, 32'h0000_0100, 1'b0);
        beat(0, 32'h0000_0100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ready", 64'(drdy[0]), 64'd1);
        chk("async_rst_count", 64'(cnt0), 64'd0);
        chk("async_rst_result", 64'(res[0]), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(0, 32'h0000_0200, 1'b0, 1'b0, 9'd1);
        beat(0, 32'h0000_0200, 1'b1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fixed_point_accumulator.md
Name: fixed_point_accumulator

Overview:
Sequential sign-magnitude fixed-point accumulator for the perceptron datapath. It sums a variable-length packet of weighted-input terms, one term per accepted beat, and presents the packet sum with a valid/ready handshake. Compared with the combinational adder it adds three things: selectable saturate/wrap overflow handling, a sticky overflow flag, and a hard term-count limit.

Parameters:
SIGN, 1, sign bit count; must be 1
Q_M, 16, integer magnitude bits
Q_N, 15, fractional magnitude bits
SATURATE, 1, 1 = clamp magnitude on overflow; 0 = discard carry (wrap)
MAX_TERMS, 256, terms per packet before forced close (>=2)
CNT_W, 9, term counter width; must hold MAX_TERMS

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
clear_in  input  1  synchronous abort; discards packet
data_in  input  SIGN+Q_M+Q_N  term, {sign, magnitude}
data_valid_in  input  1  data_in valid
data_last_in  input  1  final term of packet; qualified by data_valid_in
data_ready_out  output  1  block can accept a term
result_out  output  SIGN+Q_M+Q_N  packet sum, {sign, magnitude}
result_valid_out  output  1  result_out valid
result_ready_in  input  1  consumer accepts result
overflow_out  output  1  sticky: any magnitude overflow in this packet
forced_out  output  1  packet closed by MAX_TERMS, not data_last_in
term_count_out  output  CNT_W  terms summed in this packet

Behaviour:
- Reset: one clock (clk_in); asynchronous active-low reset on rst_n_in. Reset forces state IDLE and clears every register. After reset: result_out = 0, result_valid_out = 0, overflow_out = 0, forced_out = 0, term_count_out = 0, data_ready_out = 1 (combinational from state).
- W = SIGN+Q_M+Q_N. Magnitude width M = W-1. A beat is accepted when data_valid_in && data_ready_out.
- Add rule, acc (+) d:
  - Same sign: sum = magnitude add in M+1 bits, result sign = common sign. If bit M is set, overflow occurs: magnitude = all ones when SATURATE=1, else sum[M-1:0].
  - Opposite sign: the larger magnitude minus the smaller; sign of the larger.
  - Equal magnitudes: result is +0.
  - Any zero-magnitude result is always forced to sign 0. No -0 is ever stored or output. An input -0 is treated as +0.
- IDLE:
  - data_ready_out = 1.
  - On accept: acc = normalised data_in, count = 1, overflow = 0, forced = 0.
  - Next state: DONE if data_last_in, else ACC.
- ACC:
  - data_ready_out = 1.
  - On accept: acc = acc (+) data_in, count += 1, overflow |= this add's overflow.
  - If data_last_in, go to DONE.
  - Else if the new count == MAX_TERMS, go to DONE with forced = 1.
  - With no beat, state holds.
- DONE:
  - data_ready_out = 0.
  - result_valid_out = 1; result_out, overflow_out, forced_out and term_count_out are stable while it is high.
  - When result_ready_in = 1, go to IDLE and drop result_valid_out the next cycle. A new term is accepted no earlier than the cycle after that.
- Latency: result_valid_out rises on the clock edge after the last term is accepted. Throughput is 1 term/cycle within a packet, plus 1 cycle for DONE.
- result_out, overflow_out, forced_out and term_count_out are registered. They hold their last value outside DONE; the bench checks them only while result_valid_out = 1.
- clear_in has priority over everything else, including an accept or a result handshake in the same cycle. It goes to IDLE, clears acc, count, overflow, forced and result_valid_out, and no beat is accepted in that cycle.
- Reset asserted mid-packet is identical in effect to clear_in, but takes effect asynchronously.
- A single-term packet (data_last_in on the first beat) returns that term, normalised, with count = 1.
- Wrap mode (SATURATE=0) still sets overflow_out.

Test Plan:
- Reset: hold rst_n_in low, apply random stimulus, release -> all outputs 0, data_ready_out = 1, no result_valid_out.
- Mixed signs: send 0x0000C000 (+1.5), 0x80002000 (-0.25), 0x80010000 (-2.0, last) -> result_out = 0x80006000 (-0.75), overflow_out = 0, forced_out = 0, term_count_out = 3, valid one cycle after the third accept.
- Cancellation: send 0x00008000 then 0x80008000 (last) -> result_out = 0x00000000 (never 0x80000000). Single term 0x80000000 (last) -> result_out = 0x00000000.
- Overflow: send 0x7FFFFFFF then 0x00000001 (last).
  - SATURATE=1 -> result_out = 0x7FFFFFFF, overflow_out = 1.
  - SATURATE=0 -> result_out = 0x00000000, overflow_out = 1.
  - In both modes, a following packet starts with overflow_out = 0.
- Backpressure: complete a packet and hold result_ready_in low for 5 cycles with data_valid_in high -> data_ready_out = 0, no term accepted, result stable. Raise result_ready_in -> IDLE; the next packet sums correctly.
- Limit and abort:
  - MAX_TERMS=4: send six 0x00008000 beats with no last -> the first result is 0x00020000 with forced_out = 1 and term_count_out = 4.
  - clear_in pulsed after two terms of a packet -> no result. The next packet 0x00004000 (last) -> result_out = 0x00004000.
